// File: rtl/vga_fb_scanout.sv
// VGA scan-out: raster counters, framebuffer read requests and an output
// pipeline matched to the RAM read latency so sync, de and colour stay aligned.
module vga_fb_scanout #(
  parameter int          H_VIS        = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_VIS        = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          IMG_W        = 128,
  parameter int          IMG_H        = 128,
  parameter int          SCALE_SH     = 1,
  parameter int          X_OFF        = 192,
  parameter int          Y_OFF        = 112,
  parameter int          RD_LAT       = 1,
  parameter logic [11:0] BORDER_COLOR = 12'h000,
  parameter bit          SYNC_POL     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic        rd_en,
  output logic [7:0]  rd_x,
  output logic [7:0]  rd_y,
  input  logic [11:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic        line_start
);

  localparam logic [11:0] H_LAST  = 12'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST  = 12'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_VIS_C = 12'(H_VIS);
  localparam logic [11:0] V_VIS_C = 12'(V_VIS);
  localparam logic [11:0] HS_BEG  = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_VIS + V_FP + V_SYNC);
  localparam logic [11:0] X_BEG   = 12'(X_OFF);
  localparam logic [11:0] X_END   = 12'(X_OFF + (IMG_W << SCALE_SH));
  localparam logic [11:0] Y_BEG   = 12'(Y_OFF);
  localparam logic [11:0] Y_END   = 12'(Y_OFF + (IMG_H << SCALE_SH));

  logic [11:0] h, v;
  logic        h_last, v_last;
  logic        vis, win, hs_act, vs_act;
  logic [11:0] dx, dy;

  // Flags for the pixel being fetched; stage RD_LAT-1 lines up with rd_data.
  logic [RD_LAT-1:0] vis_p, win_p, hs_p, vs_p;

  always_comb begin
    h_last = (h == H_LAST);
    v_last = (v == V_LAST);
    vis    = (h < H_VIS_C) && (v < V_VIS_C);
    hs_act = (h >= HS_BEG) && (h < HS_END);
    vs_act = (v >= VS_BEG) && (v < VS_END);
    win    = vis && (h >= X_BEG) && (h < X_END) && (v >= Y_BEG) && (v < Y_END);
    dx     = h - X_BEG;
    dy     = v - Y_BEG;
  end

  // Read port is fire-and-forget: a request registered on one pix_en edge has
  // its data on rd_data at the pix_en edge RD_LAT ticks later; there is no stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h           <= '0;
      v           <= '0;
      rd_en       <= 1'b0;
      rd_x        <= '0;
      rd_y        <= '0;
      vis_p       <= '0;
      win_p       <= '0;
      hs_p        <= '0;
      vs_p        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      rgb         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        h <= h_last ? '0 : h + 12'd1;
        if (h_last) v <= v_last ? '0 : v + 12'd1;
        line_start  <= h_last;
        frame_start <= h_last && v_last;

        rd_en <= win;
        if (win) begin
          rd_x <= 8'(dx >> SCALE_SH);
          rd_y <= 8'(dy >> SCALE_SH);
        end

        vis_p[0] <= vis;
        win_p[0] <= win;
        hs_p[0]  <= hs_act;
        vs_p[0]  <= vs_act;
        for (int i = 1; i < RD_LAT; i++) begin
          vis_p[i] <= vis_p[i-1];
          win_p[i] <= win_p[i-1];
          hs_p[i]  <= hs_p[i-1];
          vs_p[i]  <= vs_p[i-1];
        end

        hsync <= hs_p[RD_LAT-1] ? SYNC_POL : ~SYNC_POL;
        vsync <= vs_p[RD_LAT-1] ? SYNC_POL : ~SYNC_POL;
        de    <= vis_p[RD_LAT-1];
        if (win_p[RD_LAT-1])      rgb <= rd_data;
        else if (vis_p[RD_LAT-1]) rgb <= BORDER_COLOR;
        else                      rgb <= '0;
      end
    end
  end

endmodule
